i2s_crush_scheduler: RTL and testbench

//  Control plane for the I2S bitcrusher datapath, clocked on BCLK.
//  - Detects frame boundaries on LRCLK and keeps the sample-rate-reduction counter.
//  - Emits a per-frame HOLD_SAMPLE decision and a bit-depth CRUSH_MASK.
//  - Accepts pot readings over a valid/ready handshake; applies new settings only on a frame boundary, so no word is ever crushed with mixed settings.

---
 rtl/i2s_crush_pkg.sv | 16 +
 rtl/i2s_lrclk_edge.sv | 28 ++
 rtl/i2s_crush_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_i2s_crush_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_crush_pkg.sv
// Shared types and widths for the I2S bitcrusher scheduler.
package i2s_crush_pkg;

  // Settings FSM: waiting for a pot pair, or holding one until the next frame
  typedef enum logic {
    IDLE,
    PENDING
  } sched_state_t;

  // Width of the frame counter and of the applied skip count
  localparam int unsigned COUNT_W = 8;

  // Width of the applied bit-depth value
  localparam int unsigned DEPTH_W = 5;

endpackage

// File: rtl/i2s_lrclk_edge.sv
// LRCLK frame-boundary detector for the bitcrusher scheduler.
// Right-word (rising) edges generate no events downstream, so only the
// left-word (falling) edge is decoded here.
module i2s_lrclk_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic lrclk,
  output logic fall_det,
  output logic fall_pulse
);

  logic lrclk_q;

  // Combinational detect: the cycle in which the falling edge is sampled
  assign fall_det = lrclk_q & ~lrclk;

  // Delay word select and register the left-word start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lrclk_q    <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      lrclk_q    <= lrclk;
      fall_pulse <= fall_det;
    end
  end

endmodule

// File: rtl/i2s_crush_scheduler.sv
// Control plane for the I2S bitcrusher datapath (BCLK domain).
// Tracks frames, runs the sample-rate-reduction counter, and applies pot
// settings only on frame boundaries.
// Optional feature: define CFG_HYST_EN to drop pot pairs that sit inside the
// HYST dead-band of the last applied raw codes.
module i2s_crush_scheduler
  import i2s_crush_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned POT_WIDTH  = 10,
  parameter int unsigned SUBDIV     = 100,
  parameter int unsigned MIN_DEPTH  = 4,
  parameter int unsigned HYST       = 4
) (
  input  logic                  BCLK,
  input  logic                  RST_N,
  input  logic                  LRCLK,
  input  logic [POT_WIDTH-1:0]  POT_RATE,
  input  logic [POT_WIDTH-1:0]  POT_DEPTH,
  input  logic                  POT_VALID,
  output logic                  POT_READY,
  output logic                  FRAME_START,
  output logic                  HOLD_SAMPLE,
  output logic [DATA_WIDTH-1:0] CRUSH_MASK,
  output logic [DEPTH_W-1:0]    ACTIVE_DEPTH,
  output logic [COUNT_W-1:0]    ACTIVE_SKIP,
  output logic [COUNT_W-1:0]    SAMPLE_COUNT,
  output logic                  CFG_APPLIED
);

  localparam int unsigned RATE_PROD_W  = POT_WIDTH + COUNT_W;
  localparam int unsigned DEPTH_SPAN   = DATA_WIDTH - MIN_DEPTH + 1;
  localparam int unsigned DEPTH_PROD_W = POT_WIDTH + DEPTH_W + 1;
  localparam int unsigned SUM_W        = DEPTH_W + 1;

  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(SUBDIV - 1);
  localparam logic [COUNT_W:0]   SUBDIV_EXT = (COUNT_W + 1)'(SUBDIV);
  localparam logic [SUM_W-1:0]   DEPTH_MAX  = SUM_W'(DATA_WIDTH);

  sched_state_t state, state_next;

  logic fall_det;
  logic capture;
  logic apply;
  logic hyst_drop;

  logic [RATE_PROD_W-1:0]  rate_prod;
  logic [DEPTH_PROD_W-1:0] depth_prod;
  logic [SUM_W-1:0]        depth_sum;
  logic [COUNT_W-1:0]      map_skip;
  logic [DEPTH_W-1:0]      map_depth;
  logic [DATA_WIDTH-1:0]   map_mask;

  logic [COUNT_W-1:0]      pend_skip;
  logic [DEPTH_W-1:0]      pend_depth;
  logic [DATA_WIDTH-1:0]   pend_mask;

  logic [COUNT_W-1:0]      next_count;
  logic [COUNT_W-1:0]      skip_eff;
  logic [COUNT_W:0]        hold_thresh;
  logic                    hold_next;

  i2s_lrclk_edge u_edge (
    .clk        (BCLK),
    .rst_n      (RST_N),
    .lrclk      (LRCLK),
    .fall_det   (fall_det),
    .fall_pulse (FRAME_START)
  );

  assign POT_READY = (state == IDLE);

  // Map raw pot codes to skip count, bit depth and crush mask
  always_comb begin
    rate_prod  = RATE_PROD_W'(POT_RATE) * RATE_PROD_W'(SUBDIV);
    map_skip   = COUNT_W'(rate_prod >> POT_WIDTH);
    depth_prod = DEPTH_PROD_W'(POT_DEPTH) * DEPTH_PROD_W'(DEPTH_SPAN);
    depth_sum  = SUM_W'(MIN_DEPTH) + SUM_W'(depth_prod >> POT_WIDTH);
    map_depth  = (depth_sum > DEPTH_MAX) ? DEPTH_W'(DATA_WIDTH) : DEPTH_W'(depth_sum);
    map_mask   = ~({DATA_WIDTH{1'b1}} >> map_depth);
  end

`ifdef CFG_HYST_EN
  logic [POT_WIDTH-1:0] pend_rate_raw;
  logic [POT_WIDTH-1:0] pend_depth_raw;
  logic [POT_WIDTH-1:0] last_rate_raw;
  logic [POT_WIDTH-1:0] last_depth_raw;

  function automatic logic within_band(input logic [POT_WIDTH-1:0] a,
                                       input logic [POT_WIDTH-1:0] b);
    logic [POT_WIDTH-1:0] diff;
    diff = (a > b) ? (a - b) : (b - a);
    return (32'(diff) < HYST);
  endfunction

  assign hyst_drop = within_band(POT_RATE, last_rate_raw) &&
                     within_band(POT_DEPTH, last_depth_raw);

  // Raw codes follow the settings through capture and apply
  always_ff @(posedge BCLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_rate_raw  <= '0;
      pend_depth_raw <= '0;
      last_rate_raw  <= '0;
      last_depth_raw <= '0;
    end else begin
      if (capture) begin
        pend_rate_raw  <= POT_RATE;
        pend_depth_raw <= POT_DEPTH;
      end
      if (apply) begin
        last_rate_raw  <= pend_rate_raw;
        last_depth_raw <= pend_depth_raw;
      end
    end
  end
`else
  assign hyst_drop = 1'b0;
`endif

  // Next-state logic: capture in IDLE, apply on the next frame edge in PENDING
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    apply      = 1'b0;
    unique case (state)
      IDLE: begin
        if (POT_VALID && !hyst_drop) begin
          capture    = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (fall_det) begin
          apply      = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  // Settings FSM state register
  always_ff @(posedge BCLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Hold mapped settings until the next frame boundary
  always_ff @(posedge BCLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_skip  <= '0;
      pend_depth <= '0;
      pend_mask  <= '0;
    end else if (capture) begin
      pend_skip  <= map_skip;
      pend_depth <= map_depth;
      pend_mask  <= map_mask;
    end
  end

  // Counter advance and hold decision; settings applied this frame already govern it
  always_comb begin
    next_count  = (SAMPLE_COUNT == LAST_COUNT) ? '0 : (SAMPLE_COUNT + 1'b1);
    skip_eff    = apply ? pend_skip : ACTIVE_SKIP;
    hold_thresh = SUBDIV_EXT - {1'b0, skip_eff};
    hold_next   = ({1'b0, next_count} >= hold_thresh) && (skip_eff != '0);
  end

  // Frame-rate state: counter, hold flag and active settings move with FRAME_START
  always_ff @(posedge BCLK or negedge RST_N) begin
    if (!RST_N) begin
      SAMPLE_COUNT <= '0;
      HOLD_SAMPLE  <= 1'b0;
      ACTIVE_SKIP  <= '0;
      ACTIVE_DEPTH <= DEPTH_W'(DATA_WIDTH);
      CRUSH_MASK   <= '1;
      CFG_APPLIED  <= 1'b0;
    end else begin
      CFG_APPLIED <= apply;
      if (fall_det) begin
        SAMPLE_COUNT <= next_count;
        HOLD_SAMPLE  <= hold_next;
      end
      if (apply) begin
        ACTIVE_SKIP  <= pend_skip;
        ACTIVE_DEPTH <= pend_depth;
        CRUSH_MASK   <= pend_mask;
      end
    end
  end

endmodule

// File: tb/tb_i2s_crush_scheduler.sv
// Self-checking bench for i2s_crush_scheduler: a frame-level reference model
// pushes one expected record per left-word start; a monitor pops and compares.
// Define CFG_HYST_EN for both bench and RTL to exercise the dead-band feature.
module tb_i2s_crush_scheduler;

  localparam int unsigned DW  = 24;
  localparam int unsigned PW  = 10;
  localparam int unsigned SUB = 100;
  localparam int unsigned MIN = 4;
  localparam int unsigned HY  = 4;

  logic          BCLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          LRCLK = 1'b0;
  logic [PW-1:0] POT_RATE = '0;
  logic [PW-1:0] POT_DEPTH = '0;
  logic          POT_VALID = 1'b0;
  logic          POT_READY;
  logic          FRAME_START;
  logic          HOLD_SAMPLE;
  logic [DW-1:0] CRUSH_MASK;
  logic [4:0]    ACTIVE_DEPTH;
  logic [7:0]    ACTIVE_SKIP;
  logic [7:0]    SAMPLE_COUNT;
  logic          CFG_APPLIED;

  i2s_crush_scheduler #(
    .DATA_WIDTH (DW),
    .POT_WIDTH  (PW),
    .SUBDIV     (SUB),
    .MIN_DEPTH  (MIN),
    .HYST       (HY)
  ) dut (
    .BCLK         (BCLK),
    .RST_N        (RST_N),
    .LRCLK        (LRCLK),
    .POT_RATE     (POT_RATE),
    .POT_DEPTH    (POT_DEPTH),
    .POT_VALID    (POT_VALID),
    .POT_READY    (POT_READY),
    .FRAME_START  (FRAME_START),
    .HOLD_SAMPLE  (HOLD_SAMPLE),
    .CRUSH_MASK   (CRUSH_MASK),
    .ACTIVE_DEPTH (ACTIVE_DEPTH),
    .ACTIVE_SKIP  (ACTIVE_SKIP),
    .SAMPLE_COUNT (SAMPLE_COUNT),
    .CFG_APPLIED  (CFG_APPLIED)
  );

  always #5 BCLK = ~BCLK;

  typedef struct {
    int unsigned count;
    bit          hold;
    int unsigned skip;
    int unsigned depth;
    int unsigned mask;
    bit          applied;
  } frame_t;

  frame_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (frame level)
  int unsigned m_count, m_skip, m_depth;
  int unsigned p_skip, p_depth, p_rate_raw, p_depth_raw;
  int unsigned m_last_rate, m_last_depth;
  bit          m_pending, m_prev_lr;

  // LRCLK generator state
  int unsigned half_len = 24;
  int unsigned lr_cnt   = 0;
  bit          lr_val   = 1'b0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int unsigned mask_of(input int unsigned d);
    return ((32'd1 << d) - 32'd1) << (DW - d);
  endfunction

  function automatic int unsigned absdiff(input int unsigned a, input int unsigned b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit dropped(input int unsigned r, input int unsigned d);
`ifdef CFG_HYST_EN
    return (absdiff(r, m_last_rate) < HY) && (absdiff(d, m_last_depth) < HY);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit will_fall();
    return (lr_cnt + 1 >= half_len) && lr_val;
  endfunction

  task automatic model_reset();
    m_count = 0; m_skip = 0; m_depth = DW;
    p_skip = 0; p_depth = 0; p_rate_raw = 0; p_depth_raw = 0;
    m_last_rate = 0; m_last_depth = 0;
    m_pending = 1'b0; m_prev_lr = 1'b0;
  endtask

  // One BCLK cycle of stimulus; the model decides what the next edge produces
  task automatic tick(input bit v, input int unsigned r, input int unsigned d);
    bit fall, accepted;
    frame_t e;
    @(negedge BCLK);
    if (lr_cnt + 1 >= half_len) begin
      lr_cnt = 0;
      lr_val = ~lr_val;
    end else begin
      lr_cnt++;
    end
    if (v) chk("pot_ready", POT_READY, m_pending ? 0 : 1);
    LRCLK     = lr_val;
    POT_VALID = v;
    POT_RATE  = PW'(r);
    POT_DEPTH = PW'(d);

    fall      = m_prev_lr && !lr_val;
    m_prev_lr = lr_val;
    accepted  = v && !m_pending;
    if (fall) begin
      e.applied = m_pending;
      if (m_pending) begin
        m_skip       = p_skip;
        m_depth      = p_depth;
        m_last_rate  = p_rate_raw;
        m_last_depth = p_depth_raw;
        m_pending    = 1'b0;
      end
      m_count = (m_count + 1) % SUB;
      e.count = m_count;
      e.hold  = (m_skip != 0) && (m_count >= SUB - m_skip);
      e.skip  = m_skip;
      e.depth = m_depth;
      e.mask  = mask_of(m_depth);
      exp_q.push_back(e);
    end
    if (accepted && !dropped(r, d)) begin
      m_pending   = 1'b1;
      p_skip      = (r * SUB) / 1024;
      p_depth     = MIN + (d * (DW - MIN + 1)) / 1024;
      if (p_depth > DW) p_depth = DW;
      p_rate_raw  = r;
      p_depth_raw = d;
    end
  endtask

  task automatic run(input int unsigned n);
    repeat (n) tick(1'b0, 0, 0);
  endtask

  task automatic offer(input int unsigned r, input int unsigned d);
    tick(1'b1, r, d);
  endtask

  // Present a pot pair in exactly the cycle a falling LRCLK edge is sampled
  task automatic offer_on_edge(input int unsigned r, input int unsigned d);
    int unsigned guard = 0;
    while (!will_fall() && guard < 500) begin
      tick(1'b0, 0, 0);
      guard++;
    end
    chk("edge_found", guard < 500, 1);
    tick(1'b1, r, d);
  endtask

  task automatic do_reset();
    @(negedge BCLK);
    RST_N     = 1'b0;
    POT_VALID = 1'b0;
    repeat (3) @(negedge BCLK);
    model_reset();
    lr_cnt = 0;
    chk("rst_pot_ready",    POT_READY, 1);
    chk("rst_frame_start",  FRAME_START, 0);
    chk("rst_cfg_applied",  CFG_APPLIED, 0);
    chk("rst_hold",         HOLD_SAMPLE, 0);
    chk("rst_active_skip",  ACTIVE_SKIP, 0);
    chk("rst_sample_count", SAMPLE_COUNT, 0);
    chk("rst_active_depth", ACTIVE_DEPTH, DW);
    chk("rst_crush_mask",   CRUSH_MASK, 24'hFFFFFF);
    RST_N = 1'b1;
  endtask

  // Monitor: every frame start must match the oldest expected record
  initial begin : monitor
    frame_t e;
    forever begin
      @(posedge BCLK);
      #1;
      if (RST_N) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("frame_start",  FRAME_START, 1);
          chk("sample_count", SAMPLE_COUNT, e.count);
          chk("hold_sample",  HOLD_SAMPLE, e.hold);
          chk("active_skip",  ACTIVE_SKIP, e.skip);
          chk("active_depth", ACTIVE_DEPTH, e.depth);
          chk("crush_mask",   CRUSH_MASK, e.mask);
          chk("cfg_applied",  CFG_APPLIED, e.applied);
        end else begin
          chk("no_frame_start", FRAME_START, 0);
          chk("no_cfg_applied", CFG_APPLIED, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    model_reset();
    do_reset();

    // Idle frames after reset: no hold, full mask
    run(250);

    // Rate 512 -> skip 50; depth 1023 -> 24; sweep a full counter cycle
    offer(512, 1023);
    run(5000);

    // Minimum depth
    offer(512, 0);
    run(200);

    // Handshake coinciding with a frame edge applies one frame later
    offer_on_edge(0, 1023);
    run(150);

    // Dead-band sequence (dropped only when CFG_HYST_EN is defined)
    offer(512, 512);
    run(120);
    offer(514, 513);
    run(120);
    offer(520, 520);
    run(120);

    // Static LRCLK: pending update waits, repeated valids are refused
    offer_on_edge(300, 700);
    half_len = 100000;
    lr_cnt   = 0;
    repeat (200) tick(1'b1, 900, 100);
    half_len = 24;
    lr_cnt   = 0;
    run(200);

    // Reset while pending discards the captured settings
    offer_on_edge(512, 500);
    repeat (4) tick(1'b1, 100, 100);
    do_reset();
    run(300);

    // Randomised frame lengths, handshake timing and codes
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        half_len = $urandom_range(1, 24);
        lr_cnt   = 0;
      end
      tick($urandom_range(0, 9) == 0, $urandom_range(0, 1023), $urandom_range(0, 1023));
    end
    run(60);

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
